// File: rtl/divide_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : divide_rr_arbiter
//  Description : Shares a single divide_two_inputs core between NUM_REQ
//                requesters. Each requester supplies operands through its own
//                A/B first-word-fall-through FIFOs and receives results
//                through its own result FIFO.
//
//                Operand side: a round-robin winner among the requesters whose
//                A and B FIFOs are both non-empty is popped. Its pair is staged
//                in a register and presented to the divider as a pair of
//                FIFO-style read ports (div_a_* / div_b_*).
//
//                Result side: a tag FIFO records the grant order. The divider
//                returns results in order. Each result is steered
//                combinationally to the result FIFO named by the head tag.
//
//  Ports       : clock_i / reset_i        clock, synchronous active-low reset
//                req_{a,b}_rd_en_o        pop requester A/B FIFOs
//                req_{a,b}_empty_i        requester A/B FIFO empty flags
//                req_{a,b}_dout_i         requester FIFO heads (slice i)
//                res_wr_en_o              push requester result FIFOs
//                res_full_i               requester result FIFO full flags
//                res_din_o                result data (same value on all slices)
//                div_{a,b}_rd_en_i        divider pops staged operand
//                div_{a,b}_empty_o        staged pair absent
//                div_{a,b}_dout_o         staged operand
//                div_out_wr_en_i          divider result push
//                div_out_full_o           back-pressure to divider
//                div_out_din_i            divider result data
//                grant_cnt_o              per-requester grant counters
//                                         (only with DIV_ARB_STATS_EN)
//                err_o                    sticky protocol error
//
//  Config      : DIV_ARB_STATS_EN enables 32-bit per-requester grant counters.
//  Revision    : 1.0  initial release
// ============================================================================
module divide_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,

    output logic [NUM_REQ-1:0]            req_a_rd_en_o,
    input  logic [NUM_REQ-1:0]            req_a_empty_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_dout_i,
    output logic [NUM_REQ-1:0]            req_b_rd_en_o,
    input  logic [NUM_REQ-1:0]            req_b_empty_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_dout_i,

    output logic [NUM_REQ-1:0]            res_wr_en_o,
    input  logic [NUM_REQ-1:0]            res_full_i,
    output logic [NUM_REQ*DATA_WIDTH-1:0] res_din_o,

    input  logic                          div_a_rd_en_i,
    output logic                          div_a_empty_o,
    output logic [DATA_WIDTH-1:0]         div_a_dout_o,
    input  logic                          div_b_rd_en_i,
    output logic                          div_b_empty_o,
    output logic [DATA_WIDTH-1:0]         div_b_dout_o,

    input  logic                          div_out_wr_en_i,
    output logic                          div_out_full_o,
    input  logic [DATA_WIDTH-1:0]         div_out_din_i,

`ifdef DIV_ARB_STATS_EN
    output logic [NUM_REQ*32-1:0]         grant_cnt_o,
`endif
    output logic                          err_o
);

    // ------------------------------------------------------------------------
    // Widths
    // ------------------------------------------------------------------------
    localparam int TAG_W = (NUM_REQ > 1)   ? $clog2(NUM_REQ)   : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    // Count must distinguish 0..TAG_DEPTH, i.e. TAG_DEPTH+1 states.
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       rr_q, rr_d;
    logic [DATA_WIDTH-1:0]  stage_a_q, stage_a_d;
    logic [DATA_WIDTH-1:0]  stage_b_q, stage_b_d;
    logic [TAG_W-1:0]       tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0]     w_elig;
    logic                   w_any;
    logic [TAG_W-1:0]       w_winner;
    logic [DATA_WIDTH-1:0]  w_sel_a;
    logic [DATA_WIDTH-1:0]  w_sel_b;
    logic                   w_tag_full;
    logic                   w_tag_empty;
    logic [TAG_W-1:0]       w_head_tag;
    logic                   w_head_res_full;
    logic                   w_out_full;
    logic                   w_pop;
    logic                   w_grant;
    logic                   w_staged_empty;

    // Round-robin search. Candidates are scanned from farthest (rr+NUM_REQ)
    // to nearest (rr+1). The last match wins, so the nearest eligible
    // requester after rr takes priority.
    always_comb begin
        w_elig   = ~req_a_empty_i & ~req_b_empty_i;
        w_any    = |w_elig;
        w_winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (w_elig[j] && (j == ((int'(rr_q) + k) % NUM_REQ))) begin
                    w_winner = TAG_W'(j);
                end
            end
        end
    end

    // Operand slice selection for the winner.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_winner == TAG_W'(j)) begin
                w_sel_a = req_a_dout_i[j*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b = req_b_dout_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Tag FIFO status and result routing.
    always_comb begin
        w_tag_full      = (cnt_q == CNT_W'(TAG_DEPTH));
        w_tag_empty     = (cnt_q == '0);
        w_head_tag      = tag_mem_q[rd_ptr_q];
        w_head_res_full = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_head_tag == TAG_W'(j)) begin
                w_head_res_full = res_full_i[j];
            end
        end
        w_out_full = w_tag_empty || w_head_res_full;
        w_pop      = div_out_wr_en_i && !w_out_full;
    end

    // ------------------------------------------------------------------------
    // FSM next-state / grant decision
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        w_grant        = 1'b0;
        w_staged_empty = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (w_any && !w_tag_full) begin
                    w_grant = 1'b1;
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                w_staged_empty = 1'b0;
                // The stage can only be refilled in the cycle it is drained.
                if (div_a_rd_en_i) begin
                    if (w_any && !w_tag_full) begin
                        w_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        stage_a_d = stage_a_q;
        stage_b_d = stage_b_q;
        rr_d      = rr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        if (w_grant) begin
            stage_a_d = w_sel_a;
            stage_b_d = w_sel_b;
            rr_d      = w_winner;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_grant, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if ((div_a_rd_en_i != div_b_rd_en_i) ||
            (div_a_rd_en_i && (state_q == ST_IDLE)) ||
            (div_out_wr_en_i && w_out_full)) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            rr_q      <= TAG_W'(NUM_REQ - 1);
            stage_a_q <= '0;
            stage_b_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            stage_a_q <= stage_a_d;
            stage_b_q <= stage_b_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while cnt_q != 0.
    always_ff @(posedge clock_i) begin
        if (reset_i && w_grant) begin
            tag_mem_q[wr_ptr_q] <= w_winner;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            req_a_rd_en_o[j] = reset_i && w_grant && (w_winner == TAG_W'(j));
            req_b_rd_en_o[j] = reset_i && w_grant && (w_winner == TAG_W'(j));
            res_wr_en_o[j]   = reset_i && w_pop && (w_head_tag == TAG_W'(j));
        end
    end

    assign res_din_o      = {NUM_REQ{div_out_din_i}};
    assign div_a_empty_o  = w_staged_empty;
    assign div_b_empty_o  = w_staged_empty;
    assign div_a_dout_o   = stage_a_q;
    assign div_b_dout_o   = stage_b_q;
    assign div_out_full_o = w_out_full;
    assign err_o          = err_q;

`ifdef DIV_ARB_STATS_EN
    // Per-requester grant counters, wrapping at 2^32.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
            logic [31:0] grant_cnt_q;
            always_ff @(posedge clock_i) begin
                if (!reset_i) begin
                    grant_cnt_q <= '0;
                end else if (w_grant && (w_winner == TAG_W'(g))) begin
                    grant_cnt_q <= grant_cnt_q + 32'd1;
                end
            end
            assign grant_cnt_o[g*32 +: 32] = grant_cnt_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_divide_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divide_rr_arbiter
//  Description : Self-checking bench for divide_rr_arbiter (NUM_REQ=2,
//                TAG_DEPTH=8). It runs a table of arbitration vectors and
//                directed multi-cycle sequences. It then applies randomized
//                traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divide_rr_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TD = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     a_rd, b_rd, a_empty, b_empty, res_wr, res_full;
    logic [NR*DW-1:0]  a_dout, b_dout, res_din;
    logic              div_a_rd, div_b_rd, div_a_empty, div_b_empty;
    logic [DW-1:0]     div_a_dout, div_b_dout, out_din;
    logic              out_wr, out_full, err;
`ifdef DIV_ARB_STATS_EN
    logic [NR*32-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    divide_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_DEPTH(TD)) u_dut (
        .clock_i         (clk),
        .reset_i         (rst_n),
        .req_a_rd_en_o   (a_rd),
        .req_a_empty_i   (a_empty),
        .req_a_dout_i    (a_dout),
        .req_b_rd_en_o   (b_rd),
        .req_b_empty_i   (b_empty),
        .req_b_dout_i    (b_dout),
        .res_wr_en_o     (res_wr),
        .res_full_i      (res_full),
        .res_din_o       (res_din),
        .div_a_rd_en_i   (div_a_rd),
        .div_a_empty_o   (div_a_empty),
        .div_a_dout_o    (div_a_dout),
        .div_b_rd_en_i   (div_b_rd),
        .div_b_empty_o   (div_b_empty),
        .div_b_dout_o    (div_b_dout),
        .div_out_wr_en_i (out_wr),
        .div_out_full_o  (out_full),
        .div_out_din_i   (out_din),
`ifdef DIV_ARB_STATS_EN
        .grant_cnt_o     (grant_cnt),
`endif
        .err_o           (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        a_empty  = '1;
        b_empty  = '1;
        a_dout   = '0;
        b_dout   = '0;
        res_full = '0;
        div_a_rd = 1'b0;
        div_b_rd = 1'b0;
        out_wr   = 1'b0;
        out_din  = '0;
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled #1 later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_in();
        a_empty = '0;
        b_empty = '0;
        rst_n   = 1'b0;
        #1;
        chk("rst_rd_en_gated", {a_rd, b_rd, res_wr}, '0);
        step();
        step();
        chk("rst_rd_en_gated2", {a_rd, b_rd, res_wr}, '0);
        chk("rst_div_a_empty", div_a_empty, 1'b1);
        chk("rst_tag_empty", out_full, 1'b1);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        idle_in();
    endtask

    typedef struct {
        logic [1:0] a_e;
        logic [1:0] b_e;
        logic       pop;
        logic [1:0] exp_rd;
        logic       exp_empty;
    } vec_t;

    vec_t tbl [9];

    // Reference model state
    int          m_rr;
    int          m_tags [$];
    bit          m_staged;
    logic [DW-1:0] m_sa, m_sb;
    bit          m_err;

    initial begin
        int grants;
        idle_in();
        @(negedge clk);

        // ---------------- table-driven arbitration ----------------
        tbl[0] = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b1};
        tbl[1] = '{2'b00, 2'b00, 1'b0, 2'b01, 1'b1};
        tbl[2] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0};
        tbl[3] = '{2'b00, 2'b00, 1'b1, 2'b10, 1'b0};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 2'b01, 1'b0};
        tbl[5] = '{2'b01, 2'b00, 1'b1, 2'b10, 1'b0};
        tbl[6] = '{2'b00, 2'b10, 1'b1, 2'b01, 1'b0};
        tbl[7] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0};
        tbl[8] = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            a_empty  = tbl[i].a_e;
            b_empty  = tbl[i].b_e;
            div_a_rd = tbl[i].pop;
            div_b_rd = tbl[i].pop;
            #1;
            chk($sformatf("tbl%0d_a_rd", i), a_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_b_rd", i), b_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_empty", i), div_a_empty, tbl[i].exp_empty);
            step();
        end
        idle_in();
        #1 chk("tbl_err", err, 1'b0);

        // ---------------- single operation 100/7 ----------------
        do_reset();
        a_empty = 2'b10; b_empty = 2'b10;
        a_dout  = {32'd0, 32'd100};
        b_dout  = {32'd0, 32'd7};
        #1;
        chk("single_a_rd", a_rd, 2'b01);
        chk("single_b_rd", b_rd, 2'b01);
        chk("single_pre_empty", div_a_empty, 1'b1);
        step();
        idle_in();
        #1;
        chk("single_loaded", {div_a_empty, div_b_empty}, 2'b00);
        chk("single_stage_a", div_a_dout, 32'd100);
        chk("single_stage_b", div_b_dout, 32'd7);
        chk("single_out_full", out_full, 1'b0);
        div_a_rd = 1'b1; div_b_rd = 1'b1;
        step();
        div_a_rd = 1'b0; div_b_rd = 1'b0;
        #1 chk("single_drained", div_a_empty, 1'b1);
        step();
        step();
        out_wr  = 1'b1;
        out_din = 32'd100 / 32'd7;
        #1;
        chk("single_res_wr", res_wr, 2'b01);
        chk("single_res_din", res_din, {2{32'd14}});
        step();
        out_wr = 1'b0;
        #1;
        chk("single_tag_empty", out_full, 1'b1);
        chk("single_err", err, 1'b0);

        // ---------------- alternating order and tag-full hold ----------------
        do_reset();
        a_empty = 2'b00; b_empty = 2'b00;
        for (int c = 0; c < 12; c++) begin
            div_a_rd = ~div_a_empty;
            div_b_rd = ~div_a_empty;
            #1;
            if (c < TD) chk($sformatf("order%0d", c), a_rd, 2'b01 << (c % 2));
            else        chk($sformatf("full_hold%0d", c), a_rd, 2'b00);
            step();
        end
        div_a_rd = 1'b0; div_b_rd = 1'b0;
        out_wr = 1'b1;
        for (int r = 0; r < 4; r++) begin
            out_din = 32'(r * 3 + 1);
            #1;
            chk($sformatf("route%0d", r), res_wr, 2'b01 << (r % 2));
            chk($sformatf("route%0d_din", r), res_din, {2{32'(r * 3 + 1)}});
            if (r == 0) chk("full_no_grant", a_rd, 2'b00);
            if (r == 1) chk("regrant_after_pop", a_rd, 2'b01);
            step();
        end
        idle_in();
        #1 chk("order_err", err, 1'b0);

        // ---------------- result FIFO back-pressure ----------------
        do_reset();
        a_empty = 2'b01; b_empty = 2'b01;
        #1 chk("bp_grant1", a_rd, 2'b10);
        step();
        idle_in();
        div_a_rd = 1'b1; div_b_rd = 1'b1;
        step();
        div_a_rd = 1'b0; div_b_rd = 1'b0;
        res_full = 2'b10;
        #1;
        chk("bp_full", out_full, 1'b1);
        chk("bp_no_wr", res_wr, 2'b00);
        step();
        step();
        res_full = 2'b00;
        out_wr   = 1'b1;
        out_din  = 32'hFFFF_FFFB;
        #1;
        chk("bp_released", out_full, 1'b0);
        chk("bp_res_wr", res_wr, 2'b10);
        chk("bp_res_din", res_din[DW +: DW], 32'hFFFF_FFFB);
        step();
        out_wr = 1'b0;
        #1 chk("bp_err", err, 1'b0);

        // ---------------- reset with operations in flight ----------------
        do_reset();
        a_empty = 2'b00; b_empty = 2'b00;
        for (int c = 0; c < 3; c++) begin
            div_a_rd = ~div_a_empty;
            div_b_rd = ~div_a_empty;
            step();
        end
        do_reset();
        #1;
        chk("midrst_empty", div_a_empty, 1'b1);
        chk("midrst_tags", out_full, 1'b1);
        chk("midrst_err", err, 1'b0);
        a_empty = 2'b00; b_empty = 2'b00;
        #1 chk("midrst_req0_first", a_rd, 2'b01);
        step();
        idle_in();

        // ---------------- protocol errors ----------------
        do_reset();
        out_wr = 1'b1;
        #1 chk("perr_out_full", out_full, 1'b1);
        step();
        out_wr = 1'b0;
        #1 chk("perr_drop_err", err, 1'b1);
        step(); step(); step();
        chk("perr_sticky", err, 1'b1);

        do_reset();
        div_b_rd = 1'b1;
        step();
        div_b_rd = 1'b0;
        #1 chk("perr_mismatch", err, 1'b1);

        do_reset();
        div_a_rd = 1'b1; div_b_rd = 1'b1;
        step();
        idle_in();
        #1;
        chk("perr_idle_pop", err, 1'b1);
        chk("perr_idle_empty", div_a_empty, 1'b1);

`ifdef DIV_ARB_STATS_EN
        // ---------------- grant counters ----------------
        do_reset();
        for (int c = 0; c < 8; c++) begin
            a_empty  = (c < 5) ? 2'b10 : 2'b01;
            b_empty  = 2'b00;
            div_a_rd = ~div_a_empty;
            div_b_rd = ~div_a_empty;
            step();
        end
        idle_in();
        #1 chk("stats_cnt", grant_cnt, {32'd3, 32'd5});
`endif

        // ---------------- randomized against reference model ----------------
        do_reset();
        m_rr = NR - 1;
        m_tags.delete();
        m_staged = 1'b0;
        m_sa = '0;
        m_sb = '0;
        m_err = 1'b0;
        grants = 0;
        for (int i = 0; i < 600; i++) begin
            logic [NR-1:0] elig;
            logic [NR-1:0] exp_rd, exp_res;
            bit            exp_full, can;
            int            w;

            a_empty  = NR'($urandom_range(0, 3) & $urandom_range(0, 3));
            b_empty  = NR'($urandom_range(0, 3) & $urandom_range(0, 3));
            a_dout   = {$urandom, $urandom};
            b_dout   = {$urandom, $urandom};
            res_full = ($urandom_range(0, 3) == 0) ? NR'($urandom_range(0, 3)) : '0;
            out_din  = $urandom;
            div_a_rd = m_staged && ($urandom_range(0, 3) != 0);
            div_b_rd = div_a_rd;

            elig = ~a_empty & ~b_empty;
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                if (w < 0 && elig[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            end
            can      = (w >= 0) && (m_tags.size() < TD) && (!m_staged || div_a_rd);
            exp_rd   = can ? NR'(1 << w) : '0;
            exp_full = (m_tags.size() == 0) ? 1'b1 : res_full[m_tags[0]];
            // Results come back slowly in some phases so the tag FIFO fills.
            out_wr   = !exp_full && ($urandom_range(0, ((i / 100) % 2 == 1) ? 5 : 1) == 0);
            exp_res  = (out_wr && !exp_full) ? NR'(1 << m_tags[0]) : '0;

            #1;
            chk("rnd_a_rd", a_rd, exp_rd);
            chk("rnd_b_rd", b_rd, exp_rd);
            chk("rnd_res_wr", res_wr, exp_res);
            chk("rnd_res_din", res_din, {NR{out_din}});
            chk("rnd_empty", {div_a_empty, div_b_empty}, {2{!m_staged}});
            chk("rnd_out_full", out_full, exp_full);
            chk("rnd_err", err, m_err);
            if (m_staged) begin
                chk("rnd_stage_a", div_a_dout, m_sa);
                chk("rnd_stage_b", div_b_dout, m_sb);
            end

            if (out_wr && !exp_full) void'(m_tags.pop_front());
            if (can) begin
                m_tags.push_back(w);
                m_sa     = a_dout[w*DW +: DW];
                m_sb     = b_dout[w*DW +: DW];
                m_rr     = w;
                m_staged = 1'b1;
                grants++;
            end else if (m_staged && div_a_rd) begin
                m_staged = 1'b0;
            end
            step();
        end
        idle_in();
        #1 chk("rnd_some_grants", grants > 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
